boot_io_sequencer: RTL and testbench

Parametrised successor to the hard-wired boot/run control in the core top level. Owns the board bring-up sequence: init handshake byte, length-prefixed program load into instruction memory, release of the core. In the run phase it bridges the core to the UART FIFOs with a multi-byte output serialiser and a buffered input word channel. Sits between input_fifo/output_fifo and the pipeline core/instruction memory.

---
 rtl/boot_io_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_boot_io_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_io_sequencer.sv
// Boot/run sequencer: init handshake, length-prefixed program load into instruction
// memory, core release, then a byte serialiser for core output and a one-word input buffer.
module boot_io_sequencer #(
   parameter int          DW       = 32,
   parameter int          AW       = 16,
   parameter logic [7:0]  ACK_INIT = 8'h99,
   parameter logic [7:0]  ACK_LOAD = 8'hAA,
   parameter int          TIMEOUT  = 0,
   parameter int          NBW      = $clog2(DW/8) + 1
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           init_req,
   input  logic [DW-1:0]  rx_word,
   input  logic           rx_valid,
   output logic [7:0]     tx_data,
   output logic           tx_valid,
   input  logic           tx_ready,
   output logic           imem_we,
   output logic [AW-1:0]  imem_addr,
   output logic [DW-1:0]  imem_wdata,
   output logic           core_start,
   input  logic           out_req,
   input  logic [DW-1:0]  out_data,
   input  logic [NBW-1:0] out_nbytes,
   output logic           out_busy,
   output logic           in_valid,
   output logic [DW-1:0]  in_data,
   input  logic           in_ack,
   output logic [15:0]    in_count,
   output logic [2:0]     state_o,
   output logic           err,
   output logic           ovf
);

   typedef enum logic [2:0] {
      S_WAIT_INIT = 3'd0,
      S_ACK1      = 3'd1,
      S_GET_SIZE  = 3'd2,
      S_LOAD      = 3'd3,
      S_ACK2      = 3'd4,
      S_RUN       = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   localparam int              NBYTES    = DW / 8;
   localparam int              TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]   IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   // Largest legal program is a full memory of 2**AW words.
   localparam logic [DW:0]     MAX_SIZE  = {{DW{1'b0}}, 1'b1} << AW;

   state_t           state, state_n;
   logic [DW-1:0]    size_q;
   logic [DW-1:0]    cnt;
   logic [TW-1:0]    idle;
   logic             timeout_hit;
   logic             last_word;
   logic             oversize;
   logic [DW-1:0]    shift;
   logic [NBW-1:0]   rem;
   logic             busy;
   logic [NBW-1:0]   n_clamped;

   assign timeout_hit = (TIMEOUT > 0) && !rx_valid && (idle == IDLE_LAST);
   assign last_word   = (cnt + DW'(1)) == size_q;
   assign oversize    = {1'b0, rx_word} > MAX_SIZE;
   assign out_busy    = busy;
   assign state_o     = state;

   always_comb begin
      n_clamped = out_nbytes;
      if (out_nbytes == '0)
         n_clamped = NBW'(1);
      else if (out_nbytes > NBW'(NBYTES))
         n_clamped = NBW'(NBYTES);
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_n  = state;
      tx_valid = 1'b0;
      tx_data  = '0;
      case (state)
         S_WAIT_INIT: if (init_req) state_n = S_ACK1;
         S_ACK1: begin
            tx_valid = 1'b1;
            tx_data  = ACK_INIT;
            if (tx_ready) state_n = S_GET_SIZE;
         end
         S_GET_SIZE: begin
            if (rx_valid) begin
               if (rx_word == '0)  state_n = S_ACK2;
               else if (oversize)  state_n = S_ERROR;
               else                state_n = S_LOAD;
            end else if (timeout_hit) begin
               state_n = S_ERROR;
            end
         end
         S_LOAD: begin
            if (rx_valid) begin
               if (last_word) state_n = S_ACK2;
            end else if (timeout_hit) begin
               state_n = S_ERROR;
            end
         end
         S_ACK2: begin
            tx_valid = 1'b1;
            tx_data  = ACK_LOAD;
            if (tx_ready) state_n = S_RUN;
         end
         S_RUN: begin
            tx_valid = busy;
            tx_data  = busy ? shift[7:0] : 8'h00;
         end
         S_ERROR: state_n = S_ERROR;
         default: state_n = S_WAIT_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_WAIT_INIT;
      else       state <= state_n;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_start <= 1'b0;
         size_q     <= '0;
         cnt        <= '0;
         idle       <= '0;
         shift      <= '0;
         rem        <= '0;
         busy       <= 1'b0;
         in_valid   <= 1'b0;
         in_data    <= '0;
         in_count   <= '0;
         err        <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (state == S_ACK2 && tx_ready) core_start <= 1'b1;
         if (state_n == S_ERROR)          err        <= 1'b1;

         // Idle gap between received words, only meaningful while loading.
         if ((state == S_GET_SIZE || state == S_LOAD) && !rx_valid)
            idle <= idle + TW'(1);
         else
            idle <= '0;

         case (state)
            S_GET_SIZE: begin
               if (rx_valid) begin
                  size_q <= rx_word;
                  cnt    <= '0;
               end
            end
            S_LOAD: begin
               if (rx_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= cnt[AW-1:0];
                  imem_wdata <= rx_word;
                  cnt        <= cnt + DW'(1);
               end
            end
            S_RUN: begin
               // Output serialiser: LSB byte first, one byte per tx handshake.
               if (busy) begin
                  if (tx_ready) begin
                     shift <= shift >> 8;
                     rem   <= rem - NBW'(1);
                     if (rem == NBW'(1)) busy <= 1'b0;
                  end
                  if (out_req) ovf <= 1'b1;
               end else if (out_req) begin
                  shift <= out_data;
                  rem   <= n_clamped;
                  busy  <= 1'b1;
               end

               // One-entry input buffer; a simultaneous ack frees the slot for the new word.
               if (rx_valid && (!in_valid || in_ack)) begin
                  in_data  <= rx_word;
                  in_valid <= 1'b1;
               end else if (in_ack && in_valid) begin
                  in_valid <= 1'b0;
               end
               if (rx_valid && in_valid && !in_ack) ovf      <= 1'b1;
               if (in_ack && in_valid)              in_count <= in_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_io_sequencer.sv
// Self-checking bench for boot_io_sequencer: boot/load, backpressure, size corners,
// output serialiser (table-driven), input buffer, timeout and asynchronous reset.
module tb_boot_io_sequencer;

   localparam int DW  = 32;
   localparam int AW  = 16;
   localparam int NBW = 3;

   logic           clk = 1'b0;
   logic           rstn;
   logic           init_req;
   logic [DW-1:0]  rx_word;
   logic           rx_valid;
   logic [7:0]     tx_data;
   logic           tx_valid;
   logic           tx_ready;
   logic           imem_we;
   logic [AW-1:0]  imem_addr;
   logic [DW-1:0]  imem_wdata;
   logic           core_start;
   logic           out_req;
   logic [DW-1:0]  out_data;
   logic [NBW-1:0] out_nbytes;
   logic           out_busy;
   logic           in_valid;
   logic [DW-1:0]  in_data;
   logic           in_ack;
   logic [15:0]    in_count;
   logic [2:0]     state_o;
   logic           err;
   logic           ovf;

   always #5 clk = ~clk;

   boot_io_sequencer #(.DW(DW), .AW(AW), .ACK_INIT(8'h99), .ACK_LOAD(8'hAA),
                       .TIMEOUT(50), .NBW(NBW)) dut (
      .clk(clk), .rstn(rstn), .init_req(init_req), .rx_word(rx_word), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_start(core_start),
      .out_req(out_req), .out_data(out_data), .out_nbytes(out_nbytes), .out_busy(out_busy),
      .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack), .in_count(in_count),
      .state_o(state_o), .err(err), .ovf(ovf)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } imem_exp_t;

   typedef struct {
      logic [31:0]    data;
      logic [NBW-1:0] nb;
      int             exp_n;
   } ser_vec_t;

   int        n_tests = 0;
   int        n_fail  = 0;
   logic [7:0] tx_q[$];
   imem_exp_t  imem_q[$];
   ser_vec_t   vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: every tx handshake and imem write must match the next expectation.
   imem_exp_t mon_e;
   always @(negedge clk) begin
      if (rstn) begin
         if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected: got %0h, expected no byte", tx_data);
            end else begin
               check("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
            end
         end
         if (imem_we) begin
            if (imem_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL imem_unexpected: got addr %0h data %0h, expected no write",
                        imem_addr, imem_wdata);
            end else begin
               mon_e = imem_q.pop_front();
               check("imem_addr", 64'(imem_addr), 64'(mon_e.addr));
               check("imem_wdata", 64'(imem_wdata), 64'(mon_e.data));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int c = 0;
      while (state_o !== s && c < budget) begin
         tick();
         c++;
      end
      check(name, 64'(state_o), 64'(s));
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      init_req = 1'b0; rx_valid = 1'b0; rx_word = '0; tx_ready = 1'b1;
      out_req = 1'b0; out_data = '0; out_nbytes = '0; in_ack = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic send_rx(input logic [DW-1:0] w);
      rx_word  = w;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic start_boot();
      tx_q.push_back(8'h99);
      init_req = 1'b1;
      wait_state(3'd2, 20, "boot_reach_get_size");
      init_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [31:0] d;
   int          cyc;

   initial begin
      vecs[0] = '{data: 32'h11223344, nb: 3'd3, exp_n: 3};
      vecs[1] = '{data: 32'hA1B2C3D4, nb: 3'd0, exp_n: 1};
      vecs[2] = '{data: 32'hCAFEF00D, nb: 3'd4, exp_n: 4};
      vecs[3] = '{data: 32'h01020304, nb: 3'd7, exp_n: 4};
      vecs[4] = '{data: 32'hDEADBEEF, nb: 3'd1, exp_n: 1};

      // Reset state
      rstn = 1'b1;
      init_req = 1'b0; rx_valid = 1'b0; rx_word = '0; tx_ready = 1'b1;
      out_req = 1'b0; out_data = '0; out_nbytes = '0; in_ack = 1'b0;
      #1 rstn = 1'b0;
      #1;
      check("rst_state", 64'(state_o), 64'd0);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_imem_we", 64'(imem_we), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);
      check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("rst_core_start", 64'(core_start), 64'd0);
      check("rst_out_busy", 64'(out_busy), 64'd0);
      check("rst_in_valid", 64'(in_valid), 64'd0);
      check("rst_in_data", 64'(in_data), 64'd0);
      check("rst_in_count", 64'(in_count), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      repeat (2) tick();
      rstn = 1'b1;
      tick();

      // Init handshake under backpressure
      tx_ready = 1'b0;
      init_req = 1'b1;
      tick();
      check("ack1_entered", 64'(state_o), 64'd1);
      for (int i = 0; i < 10; i++) begin
         check("ack1_hold_valid", 64'(tx_valid), 64'd1);
         check("ack1_hold_data", 64'(tx_data), 64'h99);
         tick();
      end
      check("ack1_still_waiting", 64'(state_o), 64'd1);
      tx_q.push_back(8'h99);
      tx_ready = 1'b1;
      tick();
      check("ack1_advance_one_edge", 64'(state_o), 64'd2);
      init_req = 1'b0;

      // Program load of three words
      tx_q.push_back(8'hAA);
      imem_q.push_back('{addr: 16'd0, data: 32'hA0A0_0001});
      imem_q.push_back('{addr: 16'd1, data: 32'hB0B0_0002});
      imem_q.push_back('{addr: 16'd2, data: 32'hC0C0_0003});
      send_rx(32'd3);
      check("size_to_load", 64'(state_o), 64'd3);
      send_rx(32'hA0A0_0001);
      send_rx(32'hB0B0_0002);
      check("core_held_during_load", 64'(core_start), 64'd0);
      send_rx(32'hC0C0_0003);
      check("load_done_ack2", 64'(state_o), 64'd4);
      wait_state(3'd5, 10, "boot_run_reached");
      check("boot_core_start", 64'(core_start), 64'd1);

      // Output serialiser vectors
      for (int i = 0; i < 5; i++) begin
         d = vecs[i].data;
         for (int b = 0; b < vecs[i].exp_n; b++) tx_q.push_back(d[8*b +: 8]);
         out_data   = vecs[i].data;
         out_nbytes = vecs[i].nb;
         out_req    = 1'b1;
         tick();
         out_req = 1'b0;
         check("ser_busy_after_accept", 64'(out_busy), 64'd1);
         cyc = 0;
         while (out_busy && cyc < 50) begin
            tick();
            cyc++;
         end
         check("ser_busy_cycles", 64'(cyc), 64'(vecs[i].exp_n));
      end
      check("ser_no_ovf_yet", 64'(ovf), 64'd0);

      // Second request mid-transfer is dropped and flagged
      tx_ready = 1'b0;
      tx_q.push_back(8'h44);
      tx_q.push_back(8'h33);
      tx_q.push_back(8'h22);
      out_data   = 32'h11223344;
      out_nbytes = 3'd3;
      out_req    = 1'b1;
      tick();
      out_req = 1'b0;
      check("ovl_tx_valid", 64'(tx_valid), 64'd1);
      check("ovl_first_byte", 64'(tx_data), 64'h44);
      tick();
      out_data   = 32'h55667788;
      out_nbytes = 3'd4;
      out_req    = 1'b1;
      tick();
      out_req = 1'b0;
      check("ovl_ovf_set", 64'(ovf), 64'd1);
      check("ovl_first_byte_stable", 64'(tx_data), 64'h44);
      tx_ready = 1'b1;
      cyc = 0;
      while (out_busy && cyc < 50) begin
         tick();
         cyc++;
      end
      check("ovl_busy_cycles", 64'(cyc), 64'd3);
      repeat (2) tick();
      check("ovl_no_extra_bytes", 64'(tx_valid), 64'd0);

      // Asynchronous reset while running drops core_start immediately
      #2 rstn = 1'b0;
      #1;
      check("async_rst_core_start", 64'(core_start), 64'd0);
      check("async_rst_state", 64'(state_o), 64'd0);
      check("async_rst_ovf", 64'(ovf), 64'd0);
      apply_reset();

      // Zero-size program goes straight to ACK2 with no writes
      start_boot();
      tx_q.push_back(8'hAA);
      send_rx(32'd0);
      check("zero_size_ack2", 64'(state_o), 64'd4);
      wait_state(3'd5, 10, "zero_size_run");

      // Input buffer
      send_rx(32'h1111_0001);
      check("in_x_valid", 64'(in_valid), 64'd1);
      check("in_x_data", 64'(in_data), 64'h1111_0001);
      in_ack = 1'b1;
      tick();
      in_ack = 1'b0;
      check("in_x_popped", 64'(in_valid), 64'd0);
      check("in_x_count", 64'(in_count), 64'd1);
      check("in_no_ovf", 64'(ovf), 64'd0);
      send_rx(32'h2222_0002);
      send_rx(32'h3333_0003);
      check("in_overrun_keeps_y", 64'(in_data), 64'h2222_0002);
      check("in_overrun_valid", 64'(in_valid), 64'd1);
      check("in_overrun_ovf", 64'(ovf), 64'd1);
      rx_word  = 32'h4444_0004;
      rx_valid = 1'b1;
      in_ack   = 1'b1;
      tick();
      rx_valid = 1'b0;
      in_ack   = 1'b0;
      check("in_replace_data", 64'(in_data), 64'h4444_0004);
      check("in_replace_valid", 64'(in_valid), 64'd1);
      check("in_replace_count", 64'(in_count), 64'd2);
      in_ack = 1'b1;
      tick();
      in_ack = 1'b0;
      check("in_w_popped", 64'(in_valid), 64'd0);
      check("in_w_count", 64'(in_count), 64'd3);

      // Oversize program
      apply_reset();
      start_boot();
      send_rx(32'h0001_0001);
      check("oversize_error", 64'(state_o), 64'd6);
      check("oversize_err", 64'(err), 64'd1);
      repeat (3) tick();
      check("oversize_core_idle", 64'(core_start), 64'd0);
      check("oversize_tx_idle", 64'(tx_valid), 64'd0);
      check("oversize_stays", 64'(state_o), 64'd6);

      // Exactly 2**AW words is legal
      apply_reset();
      start_boot();
      send_rx(32'h0001_0000);
      check("max_size_load", 64'(state_o), 64'd3);
      check("max_size_no_err", 64'(err), 64'd0);

      // Load timeout after one of four words
      apply_reset();
      start_boot();
      imem_q.push_back('{addr: 16'd0, data: 32'h7777_0000});
      send_rx(32'd4);
      send_rx(32'h7777_0000);
      repeat (49) tick();
      check("timeout_not_yet", 64'(state_o), 64'd3);
      tick();
      check("timeout_error", 64'(state_o), 64'd6);
      check("timeout_err", 64'(err), 64'd1);

      // Asynchronous reset mid-load
      apply_reset();
      start_boot();
      imem_q.push_back('{addr: 16'd0, data: 32'h8888_0000});
      send_rx(32'd4);
      send_rx(32'h8888_0000);
      send_rx(32'h8888_0001);
      check("midload_write_pending", 64'(imem_we), 64'd1);
      rstn = 1'b0;
      #1;
      check("midload_rst_imem_we", 64'(imem_we), 64'd0);
      check("midload_rst_imem_addr", 64'(imem_addr), 64'd0);
      check("midload_rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("midload_rst_state", 64'(state_o), 64'd0);
      check("midload_rst_tx_valid", 64'(tx_valid), 64'd0);
      apply_reset();

      check("tx_queue_drained", 64'(tx_q.size()), 64'd0);
      check("imem_queue_drained", 64'(imem_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
